// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for an RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// drives the datapath strobes. Illegal opcodes and memory timeouts trap.
// Optional build macro MC_PERF_CNT_EN adds cycle_count/retire_count ports.
//
// Handshake: imem_req/dmem_req stay high for as long as the FSM sits in
// FETCH/MEM. A transfer completes in the cycle where req and the matching
// *_ready are both high. A ready seen outside its own request state is
// ignored. MEM_TIMEOUT consecutive no-ready cycles in one request state
// cause a trap. A ready in the final allowed cycle still completes the
// transfer. MEM_TIMEOUT=0 disables the timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       branch_cond,
  output logic [2:0] state,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL
  } cls_e;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // A zero-width counter is not legal, so a disabled timeout keeps one bit.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      7'b0110011: classify = C_R;
      7'b0010011: classify = C_I;
      7'b0000011: classify = C_LOAD;
      7'b0100011: classify = C_STORE;
      7'b1100011: classify = C_BRANCH;
      default:    classify = C_ILLEGAL;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [6:0]    op_q, op_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;

  cls_e cls_in;   // class of the opcode presented during DECODE
  cls_e cls_q;    // class of the latched opcode
  logic cur_ready;
  logic timeout_hit;

  assign cls_in    = classify(opcode);
  assign cls_q     = classify(op_q);
  assign cur_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST) && !cur_ready;

  // Next-state, opcode latch, wait counter and trap cause.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && !cur_ready)
      wait_d = wait_q + 1'b1;
    else
      wait_d = '0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (cls_in == C_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          C_R, C_I:        state_d = S_WRITEBACK;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH:        state_d = S_FETCH;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Moore strobes from state and latched class; ir/pc writes and retire also qualify on ready/branch_cond.
  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_retired = 1'b0;
    trap          = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXECUTE: begin
        case (cls_q)
          C_R: alu_op = 2'b10;
          C_I: begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
          end
          C_LOAD, C_STORE: alu_src = 1'b1;
          C_BRANCH: begin
            alu_op        = 2'b01;
            pc_src        = 1'b1;
            pc_write      = branch_cond;
            instr_retired = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req      = 1'b1;
        dmem_we       = (cls_q == C_STORE);
        alu_src       = 1'b1;
        instr_retired = dmem_ready && (cls_q == C_STORE);
      end
      S_WRITEBACK: begin
        reg_write     = 1'b1;
        mem_to_reg    = (cls_q == C_LOAD);
        instr_retired = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign trap_cause = cause_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, retire_q;

  // Activity and retirement counters; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_TRAP))
        cycle_q <= cycle_q + 32'd1;
      if (instr_retired)
        retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
`endif

endmodule
